// File: rtl/rld.sv
// -----------------------------------------------------------------------------
// rld -- run-length decoder (inverse of rle)
//
// Takes (rrrr, magn, isdc) symbols and expands each zig-zag block of BLK
// coefficients back into a serial stream, one coefficient per output cycle.
// All outputs are registered: a symbol accepted at cycle t produces its first
// coefficient at t+1.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   rrrr        zero-run length preceding magn (AC symbols only)
//   magn        coefficient value; ZRL = (15,0), EOB = (0,0)
//   isdc        symbol is the DC term (position 0)
//   rrmg_valid  symbol present
//   rrmg_ready  symbol accepted on the cycle where valid && ready
//   data        decoded coefficient
//   data_valid  data carries a coefficient (no output back-pressure)
//   data_first  coefficient is position 0
//   data_last   coefficient is position BLK-1
//   err         one-cycle protocol-violation pulse
//   dbg_state   current FSM state (DC_WAIT=0, AC_WAIT=1, ZEROS=2, FILL=3)
//
// Handshake: a symbol transfers on a rising edge where rrmg_valid and
// rrmg_ready are both 1; rrmg_ready never depends combinationally on
// rrmg_valid, and the output side has no ready (data_valid is a pure strobe).
// -----------------------------------------------------------------------------
module rld #(
  parameter int DW  = 8,
  parameter int BLK = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    rrrr,
  input  logic [DW-1:0] magn,
  input  logic          isdc,
  input  logic          rrmg_valid,
  output logic          rrmg_ready,
  output logic [DW-1:0] data,
  output logic          data_valid,
  output logic          data_first,
  output logic          data_last,
  output logic          err,
  output logic [1:0]    dbg_state
);

  localparam int            PW       = $clog2(BLK);
  localparam logic [PW-1:0] LAST_POS = PW'(BLK - 1);

  typedef enum logic [1:0] {
    DC_WAIT = 2'd0,
    AC_WAIT = 2'd1,
    ZEROS   = 2'd2,
    FILL    = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pos;      // position of the next coefficient to emit
  logic [3:0]    r_zcnt;     // zeros still owed before r_magn
  logic [DW-1:0] r_magn;     // value closing the current run
  logic          r_dc_pend;  // DC symbol consumed early, emitted after padding
  logic [DW-1:0] r_dc_val;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_first;
  logic          r_last;
  logic          r_err;

  logic          w_accept;
  logic          w_at_last;
  logic [PW-1:0] w_pos_nxt;

  assign w_accept  = rrmg_valid && r_ready;
  assign w_at_last = (r_pos == LAST_POS);
  assign w_pos_nxt = w_at_last ? '0 : r_pos + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DC_WAIT;
      r_pos     <= '0;
      r_zcnt    <= '0;
      r_magn    <= '0;
      r_dc_pend <= 1'b0;
      r_dc_val  <= '0;
      r_ready   <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      case (r_state)
        DC_WAIT: begin
          if (r_dc_pend) begin
            // DC captured while the previous block was still open
            r_valid   <= 1'b1;
            r_first   <= 1'b1;
            r_data    <= r_dc_val;
            r_dc_pend <= 1'b0;
            r_ready   <= 1'b1;
            r_pos     <= PW'(1);
            r_state   <= AC_WAIT;
          end else if (w_accept) begin
            if (isdc) begin
              r_valid <= 1'b1;
              r_first <= 1'b1;
              r_data  <= magn;
              r_pos   <= PW'(1);
              r_state <= AC_WAIT;
            end else begin
              r_err <= 1'b1;  // AC symbol with no open block: dropped
            end
          end
        end
        AC_WAIT: begin
          if (w_accept) begin
            r_valid <= 1'b1;
            r_last  <= w_at_last;
            r_pos   <= w_pos_nxt;
            if (isdc) begin
              // Premature DC: pad this block, keep the DC for the next one
              r_err     <= 1'b1;
              r_dc_pend <= 1'b1;
              r_dc_val  <= magn;
              r_ready   <= 1'b0;
              r_state   <= w_at_last ? DC_WAIT : FILL;
            end else if (rrrr == 4'd0) begin
              // Either a bare coefficient or EOB; EOB's own value is the
              // first padding zero.
              r_data <= magn;
              if (w_at_last) begin
                r_state <= DC_WAIT;
              end else if (magn == '0) begin
                r_ready <= 1'b0;
                r_state <= FILL;
              end
            end else if (w_at_last) begin
              r_err   <= 1'b1;  // run cannot fit: block closes, magn lost
              r_state <= DC_WAIT;
            end else begin
              r_zcnt  <= rrrr - 4'd1;
              r_magn  <= magn;
              r_ready <= 1'b0;
              r_state <= ZEROS;
            end
          end
        end
        ZEROS: begin
          r_valid <= 1'b1;
          r_last  <= w_at_last;
          r_pos   <= w_pos_nxt;
          if (r_zcnt == 4'd0) begin
            // Ready rises with the final coefficient so the next symbol
            // follows without a gap.
            r_data  <= r_magn;
            r_ready <= 1'b1;
            r_state <= w_at_last ? DC_WAIT : AC_WAIT;
          end else begin
            r_zcnt <= r_zcnt - 4'd1;
            if (w_at_last) begin
              r_err   <= 1'b1;  // overrun: run ran past the block end
              r_ready <= 1'b1;
              r_state <= DC_WAIT;
            end
          end
        end
        FILL: begin
          r_valid <= 1'b1;
          r_last  <= w_at_last;
          r_pos   <= w_pos_nxt;
          if (w_at_last) begin
            r_ready <= !r_dc_pend;
            r_state <= DC_WAIT;
          end
        end
        default: r_state <= DC_WAIT;
      endcase
    end
  end

  assign rrmg_ready = r_ready;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign data_first = r_first;
  assign data_last  = r_last;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule
